uc_escalonador_rodada: RTL and testbench

UC_ESCALONADOR_RODADA -- requirements
Module: uc_escalonador_rodada

---
 rtl/uc_escalonador_rodada.sv | 160 ++++++++++++++++
 tb/tb_uc_escalonador_rodada.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_escalonador_rodada.sv
// Round scheduler for the asteroids game: paces each round with a tick counter, then
// hands off to the shot/asteroid coordinator and the render unit in turn.
// Optional watchdog on the MOVE/RENDERIZA handshakes: define UC_ESCALONADOR_WATCHDOG_EN.
module uc_escalonador_rodada #(
    parameter int unsigned TICKS_POR_RODADA = 16,
    parameter int unsigned WATCHDOG_LIMITE  = 64,
    parameter int unsigned LARGURA_RODADA   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      pausa,
    input  logic                      fim_jogo,
    input  logic                      fim_move_tiro_e_asteroides,
    input  logic                      fim_renderiza,
    output logic                      move_tiro_e_asteroides,
    output logic                      sinal_renderiza,
    output logic                      jogo_ativo,
    output logic [LARGURA_RODADA-1:0] rodada,
    output logic                      erro_timeout,
    output logic [4:0]                db_estado_escalonador
);

    localparam int unsigned TW = (TICKS_POR_RODADA > 1) ? $clog2(TICKS_POR_RODADA) : 1;

    typedef enum logic [2:0] {
        INICIAL     = 3'd0,
        ESPERA_TICK = 3'd1,
        MOVE        = 3'd2,
        RENDERIZA   = 3'd3,
        PAUSADO     = 3'd4,
        FIM         = 3'd5,
        ERRO        = 3'd6
    } estado_t;

    estado_t                   estado, estado_prox;
    logic [TW-1:0]             tick, tick_prox;
    logic [LARGURA_RODADA-1:0] rodada_prox;

    // Elaboration-time parameter sanity checks.
    if (TICKS_POR_RODADA < 2) begin : g_chk_ticks
        $error("TICKS_POR_RODADA must be >= 2");
    end
    if (WATCHDOG_LIMITE < 2) begin : g_chk_watchdog
        $error("WATCHDOG_LIMITE must be >= 2");
    end

`ifdef UC_ESCALONADOR_WATCHDOG_EN
    localparam int unsigned WW = (WATCHDOG_LIMITE > 1) ? $clog2(WATCHDOG_LIMITE) : 1;
    logic [WW-1:0] wd, wd_prox;
`endif

    // Next-state logic: round pacing, handshakes, pause and game-over handling.
    always_comb begin
        estado_prox = estado;
        tick_prox   = tick;
        rodada_prox = rodada;
`ifdef UC_ESCALONADOR_WATCHDOG_EN
        wd_prox     = wd;
`endif
        case (estado)
            INICIAL, FIM: begin
                if (iniciar) begin
                    estado_prox = ESPERA_TICK;
                    tick_prox   = '0;
                    rodada_prox = '0;
                end
            end
            ESPERA_TICK: begin
                if (fim_jogo) begin
                    estado_prox = FIM;
                end else if (pausa) begin
                    estado_prox = PAUSADO;
                end else if (tick == TW'(TICKS_POR_RODADA - 1)) begin
                    estado_prox = MOVE;
                    tick_prox   = '0;
`ifdef UC_ESCALONADOR_WATCHDOG_EN
                    wd_prox     = '0;
`endif
                end else begin
                    tick_prox = tick + TW'(1);
                end
            end
            MOVE: begin
                if (fim_move_tiro_e_asteroides) begin
                    estado_prox = RENDERIZA;
`ifdef UC_ESCALONADOR_WATCHDOG_EN
                    wd_prox     = '0;
                end else if (wd == WW'(WATCHDOG_LIMITE - 1)) begin
                    estado_prox = ERRO;
                end else begin
                    wd_prox = wd + WW'(1);
`endif
                end
            end
            RENDERIZA: begin
                if (fim_renderiza) begin
                    estado_prox = ESPERA_TICK;
                    rodada_prox = rodada + LARGURA_RODADA'(1);
`ifdef UC_ESCALONADOR_WATCHDOG_EN
                end else if (wd == WW'(WATCHDOG_LIMITE - 1)) begin
                    estado_prox = ERRO;
                end else begin
                    wd_prox = wd + WW'(1);
`endif
                end
            end
            PAUSADO: begin
                if (fim_jogo) begin
                    estado_prox = FIM;
                end else if (!pausa) begin
                    estado_prox = ESPERA_TICK;
                end
            end
            ERRO: begin
                estado_prox = ERRO;
            end
            default: begin
                estado_prox = INICIAL;
            end
        endcase
    end

    // State, counters and Moore outputs (decoded from the state being entered).
    always_ff @(posedge clock) begin
        if (reset) begin
            estado                 <= INICIAL;
            tick                   <= '0;
            rodada                 <= '0;
            move_tiro_e_asteroides <= 1'b0;
            sinal_renderiza        <= 1'b0;
            jogo_ativo             <= 1'b0;
            db_estado_escalonador  <= '0;
        end else begin
            estado                 <= estado_prox;
            tick                   <= tick_prox;
            rodada                 <= rodada_prox;
            move_tiro_e_asteroides <= (estado_prox == MOVE);
            sinal_renderiza        <= (estado_prox == RENDERIZA);
            jogo_ativo             <= (estado_prox == ESPERA_TICK) || (estado_prox == MOVE)
                                      || (estado_prox == RENDERIZA);
            db_estado_escalonador  <= 5'(estado_prox);
        end
    end

`ifdef UC_ESCALONADOR_WATCHDOG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wd           <= '0;
            erro_timeout <= 1'b0;
        end else begin
            wd           <= wd_prox;
            erro_timeout <= (estado_prox == ERRO);
        end
    end
`else
    assign erro_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uc_escalonador_rodada.sv
// Bench for uc_escalonador_rodada: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the round scheduler.
module tb_uc_escalonador_rodada;

    localparam int TICKS = 16;
    localparam int WDL   = 64;
    localparam int LR    = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iniciar = 1'b0;
    logic          pausa = 1'b0;
    logic          fim_jogo = 1'b0;
    logic          fim_move = 1'b0;
    logic          fim_rend = 1'b0;
    logic          move;
    logic          rend;
    logic          ativo;
    logic [LR-1:0] rodada;
    logic          erro;
    logic [4:0]    estado;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase number, ticks elapsed in round, cycles waiting, rounds done.
    int m_st   = 0;
    int m_tick = 0;
    int m_wait = 0;
    int m_rnd  = 0;

    uc_escalonador_rodada #(
        .TICKS_POR_RODADA(TICKS),
        .WATCHDOG_LIMITE (WDL),
        .LARGURA_RODADA  (LR)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .iniciar                   (iniciar),
        .pausa                     (pausa),
        .fim_jogo                  (fim_jogo),
        .fim_move_tiro_e_asteroides(fim_move),
        .fim_renderiza             (fim_rend),
        .move_tiro_e_asteroides    (move),
        .sinal_renderiza           (rend),
        .jogo_ativo                (ativo),
        .rodada                    (rodada),
        .erro_timeout              (erro),
        .db_estado_escalonador     (estado)
    );

    always #5 clock = ~clock;

    function automatic void model_step();
        if (reset) begin
            m_st = 0; m_tick = 0; m_wait = 0; m_rnd = 0;
            return;
        end
        case (m_st)
            0, 5: if (iniciar) begin m_st = 1; m_tick = 0; m_rnd = 0; end
            1: begin
                if (fim_jogo) m_st = 5;
                else if (pausa) m_st = 4;
                else begin
                    m_tick = m_tick + 1;
                    if (m_tick == TICKS) begin m_st = 2; m_tick = 0; m_wait = 0; end
                end
            end
            2: begin
                if (fim_move) begin m_st = 3; m_wait = 0; end
`ifdef UC_ESCALONADOR_WATCHDOG_EN
                else begin m_wait = m_wait + 1; if (m_wait == WDL) m_st = 6; end
`endif
            end
            3: begin
                if (fim_rend) begin m_st = 1; m_rnd = (m_rnd + 1) % (1 << LR); end
`ifdef UC_ESCALONADOR_WATCHDOG_EN
                else begin m_wait = m_wait + 1; if (m_wait == WDL) m_st = 6; end
`endif
            end
            4: begin
                if (fim_jogo) m_st = 5;
                else if (!pausa) m_st = 1;
            end
            default: ;
        endcase
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        n_tests++;
        if ({estado, move, rend, ativo, erro, rodada} !== {5'd0, 4'b0000, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d move=%b rend=%b ativo=%b erro=%b rodada=%0d, required all 0",
                     estado, move, rend, ativo, erro, rodada);
        end
    endtask

    task automatic test_latency();
        bit bad = 0;
        iniciar = 1'b1; cyc(); iniciar = 1'b0;
        n_tests++;
        if (estado !== 5'd1 || ativo !== 1'b1) begin
            n_fail++;
            $display("FAIL start: state=%0d ativo=%b, required state=1 ativo=1", estado, ativo);
        end
        for (int i = 1; i < TICKS; i++) begin
            cyc();
            if (estado !== 5'd1 || move !== 1'b0) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL latency_early: move asserted or state left 1 before %0d cycles", TICKS);
        end
        cyc();
        n_tests++;
        if (estado !== 5'd2 || move !== 1'b1 || rend !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_move: state=%0d move=%b rend=%b, required state=2 move=1 rend=0",
                     estado, move, rend);
        end
    endtask

    task automatic test_rounds();
        for (int r = 1; r <= 3; r++) begin
            fim_rend = 1'b1; cyc(); fim_rend = 1'b0;
            cyc(); cyc(); cyc();
            n_tests++;
            if (estado !== 5'd2) begin
                n_fail++;
                $display("FAIL move_hold r%0d: state=%0d, required 2", r, estado);
            end
            fim_move = 1'b1; cyc(); fim_move = 1'b0;
            n_tests++;
            if (estado !== 5'd3 || rend !== 1'b1 || move !== 1'b0) begin
                n_fail++;
                $display("FAIL to_render r%0d: state=%0d rend=%b move=%b, required 3/1/0", r, estado, rend, move);
            end
            fim_move = 1'b1; cyc(); fim_move = 1'b0;
            cyc();
            fim_rend = 1'b1; cyc(); fim_rend = 1'b0;
            n_tests++;
            if (estado !== 5'd1 || rodada !== 16'(r)) begin
                n_fail++;
                $display("FAIL round_done r%0d: state=%0d rodada=%0d, required state=1 rodada=%0d",
                         r, estado, rodada, r);
            end
            if (r < 3) for (int i = 0; i < TICKS; i++) cyc();
        end
    endtask

    task automatic test_pausa();
        bit bad = 0;
        for (int i = 0; i < 7; i++) cyc();
        pausa = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (estado !== 5'd4 || ativo !== 1'b0) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL pause_hold: state=%0d ativo=%b, required state=4 ativo=0 throughout", estado, ativo);
        end
        pausa = 1'b0; cyc();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (estado !== 5'd1) bad = 1;
        end
        cyc();
        n_tests++;
        if (bad || estado !== 5'd2) begin
            n_fail++;
            $display("FAIL pause_resume: state=%0d early_exit=%b, required MOVE (2) exactly 9 cycles after release",
                     estado, bad);
        end
    endtask

    task automatic test_fim_jogo();
        fim_jogo = 1'b1;
        cyc(); cyc(); cyc();
        fim_move = 1'b1; cyc(); fim_move = 1'b0;
        cyc();
        fim_rend = 1'b1; cyc(); fim_rend = 1'b0;
        n_tests++;
        if (estado !== 5'd1 || rodada !== 16'd4) begin
            n_fail++;
            $display("FAIL endgame_ignored: state=%0d rodada=%0d, required state=1 rodada=4", estado, rodada);
        end
        cyc(); cyc(); cyc();
        n_tests++;
        if (estado !== 5'd5 || ativo !== 1'b0 || rodada !== 16'd4) begin
            n_fail++;
            $display("FAIL endgame: state=%0d ativo=%b rodada=%0d, required state=5 ativo=0 rodada=4",
                     estado, ativo, rodada);
        end
        fim_jogo = 1'b0;
        iniciar = 1'b1; cyc(); iniciar = 1'b0;
        n_tests++;
        if (estado !== 5'd1 || rodada !== 16'd0) begin
            n_fail++;
            $display("FAIL restart: state=%0d rodada=%0d, required state=1 rodada=0", estado, rodada);
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < TICKS; i++) cyc();
        for (int i = 0; i < WDL - 1; i++) cyc();
        n_tests++;
        if (estado !== 5'd2 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_early: state=%0d erro=%b, required state=2 erro=0", estado, erro);
        end
        cyc();
`ifdef UC_ESCALONADOR_WATCHDOG_EN
        n_tests++;
        if (estado !== 5'd6 || erro !== 1'b1 || move !== 1'b0 || rend !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_trip: state=%0d erro=%b move=%b, required state=6 erro=1 move=0", estado, erro, move);
        end
`else
        for (int i = 0; i < 20; i++) cyc();
        n_tests++;
        if (estado !== 5'd2 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_absent: state=%0d erro=%b, required state=2 erro=0", estado, erro);
        end
`endif
        reset = 1'b1; cyc(); reset = 1'b0;
        n_tests++;
        if (estado !== 5'd0 || erro !== 1'b0 || move !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_reset: state=%0d erro=%b move=%b, required 0/0/0", estado, erro, move);
        end
    endtask

    task automatic test_reset_mid_render();
        iniciar = 1'b1; cyc(); iniciar = 1'b0;
        for (int i = 0; i < TICKS; i++) cyc();
        fim_move = 1'b1; cyc(); fim_move = 1'b0;
        fim_rend = 1'b1; cyc(); fim_rend = 1'b0;
        for (int i = 0; i < TICKS; i++) cyc();
        fim_move = 1'b1; cyc(); fim_move = 1'b0;
        n_tests++;
        if (estado !== 5'd3 || rodada !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_render_setup: state=%0d rodada=%0d, required state=3 rodada=1", estado, rodada);
        end
        reset = 1'b1; cyc(); reset = 1'b0;
        n_tests++;
        if ({estado, move, rend, ativo, erro, rodada} !== {5'd0, 4'b0000, 16'd0}) begin
            n_fail++;
            $display("FAIL mid_render_reset: state=%0d move=%b rend=%b ativo=%b rodada=%0d, required all 0",
                     estado, move, rend, ativo, rodada);
        end
    endtask

    task automatic test_random();
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            reset    = ($urandom_range(399) == 0);
            iniciar  = ($urandom_range(19) == 0);
            if ($urandom_range(9) == 0) pausa = ~pausa;
            fim_jogo = ($urandom_range(59) == 0);
            fim_move = ($urandom_range(3) == 0);
            fim_rend = ($urandom_range(3) == 0);
            cyc();
            n_tests++;
            if (estado !== 5'(m_st) || move !== (m_st == 2) || rend !== (m_st == 3)
                || ativo !== (m_st >= 1 && m_st <= 3) || erro !== (m_st == 6)
                || rodada !== 16'(m_rnd) || (move && rend)) begin
                n_fail++;
                $display("FAIL random cyc %0d: state=%0d move=%b rend=%b ativo=%b erro=%b rodada=%0d, required state=%0d rodada=%0d",
                         n, estado, move, rend, ativo, erro, rodada, m_st, m_rnd);
            end
        end
        reset = 1'b0; iniciar = 1'b0; pausa = 1'b0; fim_jogo = 1'b0; fim_move = 1'b0; fim_rend = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounds();
        test_pausa();
        test_fim_jogo();
        test_watchdog();
        test_reset_mid_render();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
